gpio_ext: RTL
=============

// Module: gpio_ext
// PURPOSE
//  Parametrised GPIO core, NumPins wide. Adds an input synchroniser and a per-pin debounce filter
//  with a run-time programmable length. Outputs are written via set/clear/toggle registers.
//  Per-pin interrupts are sticky and configurable as rise/fall/high/low.
//  Sits behind a simple req/rvalid register port (TL-UL adapter lives outside) and drives pads and the PLIC.
// PARAMETERS
//  NumPins    32  pin count, 1..32; register bits [31:NumPins] read 0, writes ignored
//  FilterCntW 4   width of FILTER_CYCLES and of each debounce counter
//  SyncStages 2   input synchroniser depth, >=2
// PORTS
//  clk_i          in  1        clock
//  rst_ni         in  1        async active-low reset
//  reg_req_i      in  1        access request, one per cycle, always accepted
//  reg_we_i       in  1        1=write 0=read
//  reg_addr_i     in  6        byte address, word aligned
//  reg_wdata_i    in  32       write data
//  reg_rvalid_o   out 1        response valid, exactly 1 cycle after reg_req_i
//  reg_rdata_o    out 32       read data, valid with rvalid (0 for writes/errors)
//  reg_err_o      out 1        error response, valid with rvalid
//  cio_gpio_i     in  NumPins  pad inputs, asynchronous
//  cio_gpio_o     out NumPins  pad output data
//  cio_gpio_en_o  out NumPins  pad output enable
//  intr_o         out NumPins  INTR_STATE & INTR_ENABLE
//  intr_any_o     out 1        |intr_o
// BEHAVIOUR
//  Reset: all registers, synchronisers, filter state and counters = 0, so every output is 0.
//  Register map:
//    0x00 DATA_IN RO; 0x04 DATA_OUT RW; 0x08 OUT_SET W1S; 0x0C OUT_CLR W1C; 0x10 OUT_TOG W1T
//    0x14 OE RW; 0x18 FILTER_EN RW; 0x1C FILTER_CYCLES RW [FilterCntW-1:0]
//    0x20 INTR_STATE RW1C; 0x24 INTR_ENABLE RW; 0x28 INTR_TEST WO
//    0x2C EN_RISE, 0x30 EN_FALL, 0x34 EN_LVLHIGH, 0x38 EN_LVLLOW, all RW
//  Write-only registers (OUT_SET/CLR/TOG, INTR_TEST) read 0.
//  Errors: unmapped address, addr[1:0]!=0, or write to DATA_IN -> err=1, rdata=0, no state change.
//  Writes take effect on the clock edge after the req cycle. Read data is registered (1-cycle latency).
//  Input path: SyncStages flops -> filter -> stable[i] (= DATA_IN).
//    Filter per pin, effective length N = FILTER_EN[i] ? max(FILTER_CYCLES,1) : 1.
//    Counter counts consecutive cycles with sync!=stable and clears when they agree.
//    stable toggles on the cycle the count reaches N; counter then clears.
//    Latency pad->DATA_IN = SyncStages+N cycles. A glitch shorter than N samples never reaches stable.
//    A write to FILTER_EN or FILTER_CYCLES clears all counters; stable values are kept.
//  Events per pin, using prev = stable delayed by 1 cycle (reset 0):
//    rise = ~prev&stable&EN_RISE; fall = prev&~stable&EN_FALL
//    high = stable&EN_LVLHIGH; low = ~stable&EN_LVLLOW
//    A pin high at reset produces one rise after the path latency; this is intended.
//  INTR_STATE: set by (any event | INTR_TEST write bit); cleared by W1C.
//    Set and clear of the same bit in the same cycle -> set wins.
//    An active level event re-sets the bit every cycle.
//  intr_o and intr_any_o are combinational from the state/enable flops; no extra latency.
//  Output data is updated only by register writes:
//    DATA_OUT replaces; SET |=; CLR &=~; TOG ^=.
//    Only one access per cycle, so these never coincide.
//  Reset asserted mid-operation: counters, pending interrupts and outputs return to 0 immediately.
// STRUCTURE
//  gpio_ext_pkg: register offset localparams, register-index enum, DATA_W=32.
//  gpio_ext_filter: one pin; synchroniser + counter + stable flop; ports en, cycles, clr, d, q.
//    Instantiated NumPins times via generate.
//  Top: register file/decoder, output logic, edge/level detection, interrupt state.
// TESTING
//  1 Reset, read all 15 regs -> all 0, err=0; read 0x3C and 0x05 -> err=1, rdata=0.
//  2 Write DATA_OUT=0x0000_00F0, OUT_SET=0x1, OUT_CLR=0x10, OUT_TOG=0x3
//    -> cio_gpio_o=0x0000_00E2; OE=0xFFFF_FFFF -> cio_gpio_en_o all 1.
//  3 FILTER_EN[0]=1, FILTER_CYCLES=5: 4-cycle pulse on pin0 -> DATA_IN[0] stays 0;
//    6-cycle pulse -> DATA_IN[0]=1 exactly 2+5 cycles after the edge.
//  4 EN_RISE[3]=1, INTR_ENABLE[3]=1, pin3 0->1 (filter off) -> INTR_STATE=0x8 and intr_any_o=1
//    at cycle 2+1+1; W1C 0x8 -> clears; level stays high -> no re-set.
//  5 EN_LVLHIGH[7]=1, pin7 held high, W1C bit 7 -> bit stays 1 (set wins);
//    INTR_TEST=0x100 -> bit 8 set next cycle.
//  6 NumPins=8 build: write 0xFFFF_FFFF to DATA_OUT -> reads 0x0000_00FF;
//    assert rst_ni mid-filter count -> all outputs 0 same cycle.

Source files
------------

// File: rtl/gpio_ext_pkg.sv
// Shared definitions for the gpio_ext core: bus width, register offsets
// and the address decoder that maps a byte address onto a register index.
package gpio_ext_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] ADDR_DATA_IN       = 6'h00;
    localparam logic [5:0] ADDR_DATA_OUT      = 6'h04;
    localparam logic [5:0] ADDR_OUT_SET       = 6'h08;
    localparam logic [5:0] ADDR_OUT_CLR       = 6'h0C;
    localparam logic [5:0] ADDR_OUT_TOG       = 6'h10;
    localparam logic [5:0] ADDR_OE            = 6'h14;
    localparam logic [5:0] ADDR_FILTER_EN     = 6'h18;
    localparam logic [5:0] ADDR_FILTER_CYCLES = 6'h1C;
    localparam logic [5:0] ADDR_INTR_STATE    = 6'h20;
    localparam logic [5:0] ADDR_INTR_ENABLE   = 6'h24;
    localparam logic [5:0] ADDR_INTR_TEST     = 6'h28;
    localparam logic [5:0] ADDR_EN_RISE       = 6'h2C;
    localparam logic [5:0] ADDR_EN_FALL       = 6'h30;
    localparam logic [5:0] ADDR_EN_LVLHIGH    = 6'h34;
    localparam logic [5:0] ADDR_EN_LVLLOW     = 6'h38;

    typedef enum logic [3:0] {
        REG_DATA_IN,
        REG_DATA_OUT,
        REG_OUT_SET,
        REG_OUT_CLR,
        REG_OUT_TOG,
        REG_OE,
        REG_FILTER_EN,
        REG_FILTER_CYCLES,
        REG_INTR_STATE,
        REG_INTR_ENABLE,
        REG_INTR_TEST,
        REG_EN_RISE,
        REG_EN_FALL,
        REG_EN_LVLHIGH,
        REG_EN_LVLLOW,
        REG_NONE
    } regIdx_e;

    // Misaligned and unmapped addresses both fall through to REG_NONE.
    function automatic regIdx_e decodeAddr(input logic [5:0] addr);
        case (addr)
            ADDR_DATA_IN:       return REG_DATA_IN;
            ADDR_DATA_OUT:      return REG_DATA_OUT;
            ADDR_OUT_SET:       return REG_OUT_SET;
            ADDR_OUT_CLR:       return REG_OUT_CLR;
            ADDR_OUT_TOG:       return REG_OUT_TOG;
            ADDR_OE:            return REG_OE;
            ADDR_FILTER_EN:     return REG_FILTER_EN;
            ADDR_FILTER_CYCLES: return REG_FILTER_CYCLES;
            ADDR_INTR_STATE:    return REG_INTR_STATE;
            ADDR_INTR_ENABLE:   return REG_INTR_ENABLE;
            ADDR_INTR_TEST:     return REG_INTR_TEST;
            ADDR_EN_RISE:       return REG_EN_RISE;
            ADDR_EN_FALL:       return REG_EN_FALL;
            ADDR_EN_LVLHIGH:    return REG_EN_LVLHIGH;
            ADDR_EN_LVLLOW:     return REG_EN_LVLLOW;
            default:            return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_ext_filter.sv
// One pad input: synchroniser chain followed by a debounce counter that only
// lets a new level through after it has been seen for N consecutive cycles.
module gpio_ext_filter
    import gpio_ext_pkg::*;
#(
    parameter int FilterCntW = 4,
    parameter int SyncStages = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [FilterCntW-1:0] cycles_i,
    input  logic                  clr_i,
    input  logic                  d_i,
    output logic                  q_o
);

    logic [SyncStages-1:0] r_sync;
    logic [FilterCntW-1:0] r_count;
    logic                  r_stable;
    logic                  w_sync;
    logic [FilterCntW:0]   w_len;
    logic [FilterCntW:0]   w_countNext;

    assign w_sync      = r_sync[SyncStages-1];
    assign w_countNext = {1'b0, r_count} + (FilterCntW + 1)'(1);

    // A disabled filter or a programmed length of zero both behave as N = 1.
    always_comb begin
        w_len = {1'b0, cycles_i};
        if (!en_i || cycles_i == '0) begin
            w_len = (FilterCntW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync   <= '0;
            r_count  <= '0;
            r_stable <= 1'b0;
        end else begin
            r_sync <= {r_sync[SyncStages-2:0], d_i};
            if (clr_i || (w_sync == r_stable)) begin
                r_count <= '0;
            end else if (w_countNext >= w_len) begin
                r_stable <= ~r_stable;
                r_count  <= '0;
            end else begin
                r_count <= w_countNext[FilterCntW-1:0];
            end
        end
    end

    assign q_o = r_stable;

endmodule

// File: rtl/gpio_ext.sv
// GPIO core: register file behind a req/rvalid port, set/clear/toggle output
// registers, per-pin debounced inputs and sticky rise/fall/level interrupts.
module gpio_ext
    import gpio_ext_pkg::*;
#(
    parameter int NumPins    = 32,
    parameter int FilterCntW = 4,
    parameter int SyncStages = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              reg_req_i,
    input  logic              reg_we_i,
    input  logic [5:0]        reg_addr_i,
    input  logic [DATA_W-1:0] reg_wdata_i,
    output logic              reg_rvalid_o,
    output logic [DATA_W-1:0] reg_rdata_o,
    output logic              reg_err_o,
    input  logic [NumPins-1:0] cio_gpio_i,
    output logic [NumPins-1:0] cio_gpio_o,
    output logic [NumPins-1:0] cio_gpio_en_o,
    output logic [NumPins-1:0] intr_o,
    output logic              intr_any_o
);

    logic [NumPins-1:0]    r_dataOut, r_oe, r_filterEn, r_intrState, r_intrEnable;
    logic [NumPins-1:0]    r_enRise, r_enFall, r_enHigh, r_enLow, r_prev;
    logic [FilterCntW-1:0] r_filterCycles;
    logic                  r_rvalid, r_err;
    logic [DATA_W-1:0]     r_rdata;

    regIdx_e               w_idx;
    logic                  w_err, w_wr, w_filterClr;
    logic [NumPins-1:0]    w_wdata, w_stable, w_event, w_w1c, w_test, w_intrNext;
    logic [DATA_W-1:0]     w_rdataFull;

    assign w_idx       = decodeAddr(reg_addr_i);
    assign w_err       = reg_req_i && ((w_idx == REG_NONE) || (reg_we_i && (w_idx == REG_DATA_IN)));
    assign w_wr        = reg_req_i && reg_we_i && !w_err;
    assign w_wdata     = reg_wdata_i[NumPins-1:0];
    assign w_filterClr = w_wr && ((w_idx == REG_FILTER_EN) || (w_idx == REG_FILTER_CYCLES));

    for (genvar i = 0; i < NumPins; i++) begin : g_pin
        gpio_ext_filter #(
            .FilterCntW (FilterCntW),
            .SyncStages (SyncStages)
        ) u_filter (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .en_i     (r_filterEn[i]),
            .cycles_i (r_filterCycles),
            .clr_i    (w_filterClr),
            .d_i      (cio_gpio_i[i]),
            .q_o      (w_stable[i])
        );
    end

    assign w_event = (~r_prev & w_stable & r_enRise) | (r_prev & ~w_stable & r_enFall)
                   | (w_stable & r_enHigh) | (~w_stable & r_enLow);
    assign w_w1c   = (w_wr && (w_idx == REG_INTR_STATE)) ? w_wdata : '0;
    assign w_test  = (w_wr && (w_idx == REG_INTR_TEST))  ? w_wdata : '0;
    // Clear is applied first so a same-cycle event or test bit wins.
    assign w_intrNext = (r_intrState & ~w_w1c) | w_event | w_test;

    always_comb begin
        w_rdataFull = '0;
        case (w_idx)
            REG_DATA_IN:       w_rdataFull[NumPins-1:0]    = w_stable;
            REG_DATA_OUT:      w_rdataFull[NumPins-1:0]    = r_dataOut;
            REG_OE:            w_rdataFull[NumPins-1:0]    = r_oe;
            REG_FILTER_EN:     w_rdataFull[NumPins-1:0]    = r_filterEn;
            REG_FILTER_CYCLES: w_rdataFull[FilterCntW-1:0] = r_filterCycles;
            REG_INTR_STATE:    w_rdataFull[NumPins-1:0]    = r_intrState;
            REG_INTR_ENABLE:   w_rdataFull[NumPins-1:0]    = r_intrEnable;
            REG_EN_RISE:       w_rdataFull[NumPins-1:0]    = r_enRise;
            REG_EN_FALL:       w_rdataFull[NumPins-1:0]    = r_enFall;
            REG_EN_LVLHIGH:    w_rdataFull[NumPins-1:0]    = r_enHigh;
            REG_EN_LVLLOW:     w_rdataFull[NumPins-1:0]    = r_enLow;
            default:           w_rdataFull = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dataOut      <= '0;
            r_oe           <= '0;
            r_filterEn     <= '0;
            r_filterCycles <= '0;
            r_intrState    <= '0;
            r_intrEnable   <= '0;
            r_enRise       <= '0;
            r_enFall       <= '0;
            r_enHigh       <= '0;
            r_enLow        <= '0;
            r_prev         <= '0;
            r_rvalid       <= 1'b0;
            r_rdata        <= '0;
            r_err          <= 1'b0;
        end else begin
            r_prev      <= w_stable;
            r_intrState <= w_intrNext;
            r_rvalid    <= reg_req_i;
            r_err       <= w_err;
            r_rdata     <= (reg_req_i && !reg_we_i && !w_err) ? w_rdataFull : '0;
            if (w_wr) begin
                case (w_idx)
                    REG_DATA_OUT:      r_dataOut      <= w_wdata;
                    REG_OUT_SET:       r_dataOut      <= r_dataOut | w_wdata;
                    REG_OUT_CLR:       r_dataOut      <= r_dataOut & ~w_wdata;
                    REG_OUT_TOG:       r_dataOut      <= r_dataOut ^ w_wdata;
                    REG_OE:            r_oe           <= w_wdata;
                    REG_FILTER_EN:     r_filterEn     <= w_wdata;
                    REG_FILTER_CYCLES: r_filterCycles <= reg_wdata_i[FilterCntW-1:0];
                    REG_INTR_ENABLE:   r_intrEnable   <= w_wdata;
                    REG_EN_RISE:       r_enRise       <= w_wdata;
                    REG_EN_FALL:       r_enFall       <= w_wdata;
                    REG_EN_LVLHIGH:    r_enHigh       <= w_wdata;
                    REG_EN_LVLLOW:     r_enLow        <= w_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign reg_rvalid_o  = r_rvalid;
    assign reg_rdata_o   = r_rdata;
    assign reg_err_o     = r_err;
    assign cio_gpio_o    = r_dataOut;
    assign cio_gpio_en_o = r_oe;
    assign intr_o        = r_intrState & r_intrEnable;
    assign intr_any_o    = |intr_o;

endmodule
